// File: rtl/rat_pkg.sv
// Shared types for the RAT flag block: flag-load source select.
package rat_pkg;

   typedef enum logic {
      FLG_SRC_ALU  = 1'b0,
      FLG_SRC_SHAD = 1'b1
   } flg_src_e;

endpackage : rat_pkg

// File: rtl/int_sync.sv
// Two-flop synchronizer for an asynchronous request, followed by a
// rising-edge detector; EDGE is high for one cycle per low-to-high transition.
module int_sync (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic EDGE
);

   logic sync_1;
   logic sync_2;
   logic sync_3;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         sync_3 <= 1'b0;
      end else begin
         sync_1 <= D;
         sync_2 <= sync_1;
         sync_3 <= sync_2;
      end
   end

   assign EDGE = sync_2 & ~sync_3;

endmodule : int_sync

// File: rtl/rat_flags.sv
// Carry/zero/interrupt-enable flags with interrupt pending logic.
// Optional shadow C/Z registers are built when RAT_FLAGS_SHADOW_EN is defined.
module rat_flags
   import rat_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic C_IN,
   input  logic Z_IN,
   input  logic FLG_LD,
   input  logic FLG_LD_SEL,
   input  logic FLG_C_SET,
   input  logic FLG_C_CLR,
   input  logic FLG_SHAD_LD,
   input  logic I_SET,
   input  logic I_CLR,
   input  logic INTR,
   input  logic INT_ACK,
   output logic C_FLAG,
   output logic Z_FLAG,
   output logic I_FLAG,
   output logic INT_OUT
);

   logic     c_q;
   logic     z_q;
   logic     i_q;
   logic     pend_q;
   logic     edge_det;
   logic     ld_en;
   logic     c_ld;
   logic     z_ld;
   flg_src_e src;

   assign src = flg_src_e'(FLG_LD_SEL);

   int_sync u_int_sync (
      .CLK  (CLK),
      .RST  (RST),
      .D    (INTR),
      .EDGE (edge_det)
   );

`ifdef RAT_FLAGS_SHADOW_EN
   logic shad_c;
   logic shad_z;

   // Shadow captures the pre-edge flags, so a same-cycle shadow load and
   // shadow restore swaps the two register sets.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shad_c <= 1'b0;
         shad_z <= 1'b0;
      end else if (FLG_SHAD_LD) begin
         shad_c <= c_q;
         shad_z <= z_q;
      end
   end

   always_comb begin
      ld_en = FLG_LD;
      c_ld  = C_IN;
      z_ld  = Z_IN;
      if (src == FLG_SRC_SHAD) begin
         c_ld = shad_c;
         z_ld = shad_z;
      end
   end
`else
   logic unused_shad_ld;
   assign unused_shad_ld = FLG_SHAD_LD;

   // No shadow storage: a shadow-sourced load degenerates to hold.
   always_comb begin
      ld_en = FLG_LD;
      c_ld  = C_IN;
      z_ld  = Z_IN;
      if (src == FLG_SRC_SHAD) begin
         ld_en = 1'b0;
      end
   end
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         c_q <= 1'b0;
         z_q <= 1'b0;
      end else begin
         if (FLG_C_CLR) begin
            c_q <= 1'b0;
         end else if (FLG_C_SET) begin
            c_q <= 1'b1;
         end else if (ld_en) begin
            c_q <= c_ld;
         end
         if (ld_en) begin
            z_q <= z_ld;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         i_q <= 1'b0;
      end else if (I_CLR) begin
         i_q <= 1'b0;
      end else if (I_SET) begin
         i_q <= 1'b1;
      end
   end

   // A fresh edge beats an acknowledge in the same cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pend_q <= 1'b0;
      end else if (edge_det) begin
         pend_q <= 1'b1;
      end else if (INT_ACK) begin
         pend_q <= 1'b0;
      end
   end

   assign C_FLAG  = c_q;
   assign Z_FLAG  = z_q;
   assign I_FLAG  = i_q;
   assign INT_OUT = pend_q & i_q;

endmodule : rat_flags

// File: tb/tb_rat_flags.sv
// Directed self-checking bench for rat_flags; expectations follow the
// shadow build when RAT_FLAGS_SHADOW_EN is defined.
module tb_rat_flags;

   logic CLK = 1'b0;
   logic RST, C_IN, Z_IN, FLG_LD, FLG_LD_SEL, FLG_C_SET, FLG_C_CLR;
   logic FLG_SHAD_LD, I_SET, I_CLR, INTR, INT_ACK;
   logic C_FLAG, Z_FLAG, I_FLAG, INT_OUT;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 CLK = ~CLK;

   rat_flags dut (
      .CLK(CLK), .RST(RST), .C_IN(C_IN), .Z_IN(Z_IN), .FLG_LD(FLG_LD),
      .FLG_LD_SEL(FLG_LD_SEL), .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR),
      .FLG_SHAD_LD(FLG_SHAD_LD), .I_SET(I_SET), .I_CLR(I_CLR), .INTR(INTR),
      .INT_ACK(INT_ACK), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
      .INT_OUT(INT_OUT)
   );

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic idle_ctl();
      FLG_LD = 0; FLG_LD_SEL = 0; FLG_C_SET = 0; FLG_C_CLR = 0;
      FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
   endtask

   task automatic load_flags(input logic c, input logic z, input logic sel);
      C_IN = c; Z_IN = z; FLG_LD = 1; FLG_LD_SEL = sel;
      step();
      idle_ctl();
   endtask

   task automatic test_reset();
      RST = 1; C_IN = 0; Z_IN = 0; INTR = 0;
      idle_ctl();
      #2;
      total_cnt++;
      if ({C_FLAG, Z_FLAG, I_FLAG, INT_OUT} !== 4'b0000)
         $display("FAIL reset_outputs: got %b expected 0000", {C_FLAG, Z_FLAG, I_FLAG, INT_OUT});
      else pass_cnt++;
      step(2);
      RST = 0;
      step();
      total_cnt++;
      if ({C_FLAG, Z_FLAG, I_FLAG, INT_OUT} !== 4'b0000)
         $display("FAIL reset_release: got %b expected 0000", {C_FLAG, Z_FLAG, I_FLAG, INT_OUT});
      else pass_cnt++;
   endtask

   task automatic test_load();
      load_flags(1, 0, 0);
      total_cnt++;
      if ({C_FLAG, Z_FLAG} !== 2'b10)
         $display("FAIL load_alu_10: got %b expected 10", {C_FLAG, Z_FLAG});
      else pass_cnt++;
      load_flags(0, 1, 0);
      total_cnt++;
      if ({C_FLAG, Z_FLAG} !== 2'b01)
         $display("FAIL load_alu_01: got %b expected 01", {C_FLAG, Z_FLAG});
      else pass_cnt++;
      step(2);
      total_cnt++;
      if ({C_FLAG, Z_FLAG} !== 2'b01)
         $display("FAIL hold: got %b expected 01", {C_FLAG, Z_FLAG});
      else pass_cnt++;
   endtask

   task automatic test_c_priority();
      FLG_C_SET = 1; step(); idle_ctl();
      total_cnt++;
      if ({C_FLAG, Z_FLAG} !== 2'b11)
         $display("FAIL c_set: got %b expected 11", {C_FLAG, Z_FLAG});
      else pass_cnt++;
      FLG_C_SET = 1; FLG_C_CLR = 1; step(); idle_ctl();
      total_cnt++;
      if (C_FLAG !== 1'b0)
         $display("FAIL c_clr_over_set: got %b expected 0", C_FLAG);
      else pass_cnt++;
      C_IN = 0; Z_IN = 0; FLG_LD = 1; FLG_C_SET = 1; step(); idle_ctl();
      total_cnt++;
      if ({C_FLAG, Z_FLAG} !== 2'b10)
         $display("FAIL c_set_over_ld: got %b expected 10", {C_FLAG, Z_FLAG});
      else pass_cnt++;
      C_IN = 1; Z_IN = 1; FLG_LD = 1; FLG_C_CLR = 1; step(); idle_ctl();
      total_cnt++;
      if ({C_FLAG, Z_FLAG} !== 2'b01)
         $display("FAIL c_clr_over_ld: got %b expected 01", {C_FLAG, Z_FLAG});
      else pass_cnt++;
   endtask

   task automatic test_shadow();
      logic [1:0] exp;
      load_flags(1, 1, 0);
      FLG_SHAD_LD = 1; step(); idle_ctl();
      load_flags(0, 0, 0);
      total_cnt++;
      if ({C_FLAG, Z_FLAG} !== 2'b00)
         $display("FAIL shad_alu_00: got %b expected 00", {C_FLAG, Z_FLAG});
      else pass_cnt++;
      load_flags(0, 0, 1);
`ifdef RAT_FLAGS_SHADOW_EN
      exp = 2'b11;
`else
      exp = 2'b00;
`endif
      total_cnt++;
      if ({C_FLAG, Z_FLAG} !== exp)
         $display("FAIL shad_restore: got %b expected %b", {C_FLAG, Z_FLAG}, exp);
      else pass_cnt++;
      // flags=exp; load ALU 1/0 to make them differ from shadow (11 or none)
      load_flags(1, 0, 0);
      // swap: flags <- old shadow, shadow <- 10
      FLG_SHAD_LD = 1; C_IN = 0; Z_IN = 0; FLG_LD = 1; FLG_LD_SEL = 1;
      step(); idle_ctl();
`ifdef RAT_FLAGS_SHADOW_EN
      exp = 2'b11;
`else
      exp = 2'b10;
`endif
      total_cnt++;
      if ({C_FLAG, Z_FLAG} !== exp)
         $display("FAIL shad_swap_flags: got %b expected %b", {C_FLAG, Z_FLAG}, exp);
      else pass_cnt++;
      load_flags(0, 0, 1);
      exp = 2'b10;
      total_cnt++;
      if ({C_FLAG, Z_FLAG} !== exp)
         $display("FAIL shad_swap_shadow: got %b expected %b", {C_FLAG, Z_FLAG}, exp);
      else pass_cnt++;
   endtask

   task automatic test_i_priority();
      I_SET = 1; I_CLR = 1; step(); idle_ctl();
      total_cnt++;
      if (I_FLAG !== 1'b0)
         $display("FAIL i_clr_over_set: got %b expected 0", I_FLAG);
      else pass_cnt++;
   endtask

   task automatic test_int_masked();
      INTR = 1;
      step(4);
      total_cnt++;
      if (INT_OUT !== 1'b0)
         $display("FAIL int_masked: got %b expected 0", INT_OUT);
      else pass_cnt++;
      I_SET = 1; step(); idle_ctl();
      total_cnt++;
      if ({I_FLAG, INT_OUT} !== 2'b11)
         $display("FAIL int_unmask: got %b expected 11", {I_FLAG, INT_OUT});
      else pass_cnt++;
      INT_ACK = 1; step(); idle_ctl();
      total_cnt++;
      if (INT_OUT !== 1'b0)
         $display("FAIL int_ack: got %b expected 0", INT_OUT);
      else pass_cnt++;
   endtask

   task automatic test_int_hold();
      logic seen;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (INT_OUT !== 1'b0) seen = 1;
      end
      total_cnt++;
      if (seen !== 1'b0)
         $display("FAIL int_level_hold: got %b expected 0", seen);
      else pass_cnt++;
      INTR = 0; step(4);
      INTR = 1;
      step(2);
      total_cnt++;
      if (INT_OUT !== 1'b0)
         $display("FAIL int_latency_early: got %b expected 0", INT_OUT);
      else pass_cnt++;
      step();
      total_cnt++;
      if (INT_OUT !== 1'b1)
         $display("FAIL int_latency_3: got %b expected 1", INT_OUT);
      else pass_cnt++;
   endtask

   task automatic test_ack_edge();
      INTR = 0; step(4);
      INTR = 1;
      step(2);
      INT_ACK = 1; step(); idle_ctl();
      total_cnt++;
      if (INT_OUT !== 1'b1)
         $display("FAIL ack_edge_same_cycle: got %b expected 1", INT_OUT);
      else pass_cnt++;
      INT_ACK = 1; step(); idle_ctl();
      total_cnt++;
      if (INT_OUT !== 1'b0)
         $display("FAIL ack_after_edge: got %b expected 0", INT_OUT);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      load_flags(1, 1, 0);
      INTR = 0; step(4);
      INTR = 1; step(3);
      total_cnt++;
      if ({C_FLAG, Z_FLAG, I_FLAG, INT_OUT} !== 4'b1111)
         $display("FAIL pre_reset_state: got %b expected 1111", {C_FLAG, Z_FLAG, I_FLAG, INT_OUT});
      else pass_cnt++;
      INTR = 0; step(4);
      INTR = 1; step();
      #2 RST = 1; INTR = 0;
      #1;
      total_cnt++;
      if ({C_FLAG, Z_FLAG, I_FLAG, INT_OUT} !== 4'b0000)
         $display("FAIL reset_async: got %b expected 0000", {C_FLAG, Z_FLAG, I_FLAG, INT_OUT});
      else pass_cnt++;
      step(2);
      RST = 0;
      I_SET = 1; step(); idle_ctl();
      step(4);
      total_cnt++;
      if ({I_FLAG, INT_OUT} !== 2'b10)
         $display("FAIL reset_discard_pend: got %b expected 10", {I_FLAG, INT_OUT});
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_load();
      test_c_priority();
      test_shadow();
      test_i_priority();
      test_int_masked();
      test_int_hold();
      test_ack_edge();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_rat_flags

// File: doc/rat_flags.md
RAT_FLAGS -- requirements
Module: rat_flags

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port C_IN  input  1  carry result from ALU.
REQ-004 SHALL have port Z_IN  input  1  zero result from ALU.
REQ-005 SHALL have port FLG_LD  input  1  load C and Z from selected source.
REQ-006 SHALL have port FLG_LD_SEL  input  1  source select: 0 ALU, 1 shadow.
REQ-007 SHALL have port FLG_C_SET / FLG_C_CLR  input  1 each  force C to 1 / 0.
REQ-008 SHALL have port FLG_SHAD_LD  input  1  copy C, Z into shadow registers.
REQ-009 SHALL have port I_SET / I_CLR  input  1 each  set / clear interrupt enable.
REQ-010 SHALL have port INTR  input  1  external interrupt request, asynchronous to CLK.
REQ-011 SHALL have port INT_ACK  input  1  control unit accepted interrupt.
REQ-012 SHALL have ports C_FLAG, Z_FLAG, I_FLAG  output  1 each  registered flags.
REQ-013 SHALL have port INT_OUT  output  1  pending AND I_FLAG, combinational from registers.

Function
REQ-014 SHALL update C per cycle by priority: FLG_C_CLR > FLG_C_SET > FLG_LD > hold.
REQ-015 SHALL update Z only on FLG_LD; otherwise hold.
REQ-016 SHALL, on FLG_LD with FLG_LD_SEL=0, take C_IN/Z_IN; with FLG_LD_SEL=1, take shadow C/Z.
REQ-017 SHALL make loaded flags visible on outputs one cycle after the load edge (latency 1).
REQ-018 SHALL, on FLG_SHAD_LD, capture pre-edge C_FLAG/Z_FLAG, so simultaneous FLG_LD stores old values.
REQ-019 SHALL, on simultaneous FLG_SHAD_LD and FLG_LD with FLG_LD_SEL=1, swap: flags get old shadow, shadow gets old flags.
REQ-020 SHALL update I by priority: I_CLR > I_SET > hold.
REQ-021 SHALL pass INTR through a two-flop synchronizer, then a rising-edge detector (third flop).
REQ-022 SHALL set a pending bit on a detected rising edge, independent of I_FLAG.
REQ-023 SHALL clear pending on INT_ACK; a detected edge in the same cycle wins, so pending stays 1.
REQ-024 SHALL hold INTR level-high without re-setting pending; a new low-to-high transition is required.
REQ-025 SHALL assert INT_OUT no earlier than 3 CLK edges after INTR rises, and only while I_FLAG=1.

Reset
REQ-026 SHALL, on RST=1, immediately clear C, Z, I, shadow C/Z, synchronizer and edge flops, and pending; all outputs 0.
REQ-027 SHALL, on RST mid-operation, discard a pending interrupt and any in-flight INTR edge.

Configuration
REQ-028 SHALL use macro RAT_FLAGS_SHADOW_EN to include shadow registers.
REQ-029 SHALL, with RAT_FLAGS_SHADOW_EN defined, behave per REQ-016, REQ-018 and REQ-019.
REQ-030 SHALL, without RAT_FLAGS_SHADOW_EN, omit shadow registers, ignore FLG_SHAD_LD, and treat FLG_LD with FLG_LD_SEL=1 as hold.

Structure
REQ-031 SHALL take the flag-source enum (FLG_SRC_ALU=0, FLG_SRC_SHAD=1) from shared package rat_pkg.
REQ-032 SHALL implement the synchronizer and edge detector as sub-module int_sync, with ports CLK, RST, D and EDGE.

Verification
REQ-033 SHALL verify that C_IN=1, Z_IN=0, FLG_LD=1, SEL=0 gives C_FLAG=1 and Z_FLAG=0 next cycle; FLG_C_CLR and FLG_C_SET together gives C_FLAG=0.
REQ-034 SHALL verify that with C=1, Z=1, pulsing FLG_SHAD_LD, then loading ALU values 0/0, then FLG_LD with SEL=1, restores C=1 and Z=1.
REQ-035 SHALL verify that with I_FLAG=0, an INTR rise gives INT_OUT=0; a later I_SET gives INT_OUT=1 next cycle; INT_ACK then gives INT_OUT=0.
REQ-036 SHALL verify that INTR held high 20 cycles after INT_ACK does not re-assert INT_OUT; INTR low then high re-asserts it.
REQ-037 SHALL verify that an INTR edge arriving at the detector in the INT_ACK cycle leaves pending at 1.
REQ-038 SHALL verify that RST asserted mid-cycle with pending=1 and C/Z/I=1 drives all outputs to 0 before the next CLK edge.
